extensor_contador: RTL and testbench

- Downstream stage of the 4-bit mode counter. Consumes its Q/rco/load outputs plus the shared enable/mode controls.
- Cascades rco into a high-order count, forming a wide aligned total.
- Counts wrap events and keeps sticky overflow/underflow/miss flags.
- Exposes a one-entry snapshot register with a valid/ready handshake, used by the bench monitor or a bus reader.

---
 rtl/extensor_contador.sv | 175 +++++++++++++++++
 tb/tb_extensor_contador.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/extensor_contador.sv
// Extends a 4-bit mode counter into a wide aligned total,
// counts wrap events and offers a one-entry snapshot register.
module extensor_contador #(
    parameter int HI_W  = 4,
    parameter int EVT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [3:0]         Q,
    input  logic               rco,
    input  logic               load,
    input  logic               clr_flags,
    input  logic               snap_req,
    input  logic               snap_ready,
    output logic [HI_W+3:0]    total,
    output logic [EVT_W-1:0]   evt_cnt,
    output logic               ovf,
    output logic               udf,
    output logic               snap_valid,
    output logic [HI_W+3:0]    snap_total,
    output logic [EVT_W-1:0]   snap_evt,
    output logic               snap_miss
);

    localparam int TOT_W = HI_W + 4;

    localparam logic [HI_W-1:0]  HI_MAX  = {HI_W{1'b1}};
    localparam logic [HI_W-1:0]  HI_ONE  = {{(HI_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_DN3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } snap_state_t;

    snap_state_t       state;
    snap_state_t       state_next;

    logic [HI_W-1:0]   hi;
    logic [HI_W-1:0]   hi_next;
    logic [TOT_W-1:0]  total_next;
    logic [EVT_W-1:0]  evt_base;
    logic [EVT_W-1:0]  evt_next;

    logic              wrap;
    logic              ovf_set;
    logic              udf_set;
    logic              miss_set;
    logic              capture;
    logic              ovf_next;
    logic              udf_next;
    logic              miss_next;

    // A wrap only counts when the counter was really stepping, not loading.
    assign wrap       = enable & rco & ~load;
    assign total_next = {hi_next, Q};
    assign snap_valid = (state == FULL);

    // High-order step: load clears, otherwise follow the counter direction.
    always_comb begin
        hi_next = hi;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (load) begin
            hi_next = '0;
        end else if (wrap) begin
            unique case (mode)
                MODE_UP: begin
                    hi_next = hi + HI_ONE;
                    ovf_set = (hi == HI_MAX);
                end
                MODE_DN, MODE_DN3: begin
                    hi_next = hi - HI_ONE;
                    udf_set = (hi == '0);
                end
                MODE_LOAD: begin
                    hi_next = hi;
                end
                default: begin
                    hi_next = hi;
                end
            endcase
        end
    end

    // Event count: clear first, then a same-cycle wrap still lands as 1.
    always_comb begin
        evt_base = clr_flags ? '0 : evt_cnt;
        evt_next = evt_base;
        if (wrap && (evt_base != EVT_MAX)) begin
            evt_next = evt_base + EVT_ONE;
        end
    end

    // Snapshot control: capture only from EMPTY, requests while FULL are lost.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        miss_set   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (snap_req) begin
                    capture    = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                miss_set = snap_req;
                if (snap_ready) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        ovf_next  = (clr_flags ? 1'b0 : ovf) | ovf_set;
        udf_next  = (clr_flags ? 1'b0 : udf) | udf_set;
        miss_next = (clr_flags ? 1'b0 : snap_miss) | miss_set;
    end

    // Count state: extension, aligned total and event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            total   <= '0;
            evt_cnt <= '0;
        end else begin
            hi      <= hi_next;
            total   <= total_next;
            evt_cnt <= evt_next;
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf       <= 1'b0;
            udf       <= 1'b0;
            snap_miss <= 1'b0;
        end else begin
            ovf       <= ovf_next;
            udf       <= udf_next;
            snap_miss <= miss_next;
        end
    end

    // Snapshot register: data only moves on capture, so it is stable while FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            snap_total <= '0;
            snap_evt   <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                snap_total <= total_next;
                snap_evt   <= evt_next;
            end
        end
    end

endmodule

// File: tb/tb_extensor_contador.sv
// Scoreboard bench for extensor_contador: a behavioural model pushes
// expected outputs per driven cycle, popped and compared after the edge.
module tb_extensor_contador;

    localparam int HI_W  = 4;
    localparam int EVT_W = 8;
    localparam int TOT_W = HI_W + 4;
    localparam int HMAX  = (1 << HI_W) - 1;
    localparam int EMAX  = (1 << EVT_W) - 1;

    typedef struct {
        logic [TOT_W-1:0] total;
        logic [EVT_W-1:0] evt;
        logic             ovf;
        logic             udf;
        logic             sv;
        logic [TOT_W-1:0] stot;
        logic [EVT_W-1:0] sevt;
        logic             miss;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [3:0]       Q;
    logic             rco;
    logic             load;
    logic             clr_flags;
    logic             snap_req;
    logic             snap_ready;
    logic [TOT_W-1:0] total;
    logic [EVT_W-1:0] evt_cnt;
    logic             ovf;
    logic             udf;
    logic             snap_valid;
    logic [TOT_W-1:0] snap_total;
    logic [EVT_W-1:0] snap_evt;
    logic             snap_miss;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;
    int cq       = 0;

    int m_hi, m_evt, m_ovf, m_udf, m_miss, m_sv, m_stot, m_sevt, m_total;

    extensor_contador #(
        .HI_W (HI_W),
        .EVT_W(EVT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .Q         (Q),
        .rco       (rco),
        .load      (load),
        .clr_flags (clr_flags),
        .snap_req  (snap_req),
        .snap_ready(snap_ready),
        .total     (total),
        .evt_cnt   (evt_cnt),
        .ovf       (ovf),
        .udf       (udf),
        .snap_valid(snap_valid),
        .snap_total(snap_total),
        .snap_evt  (snap_evt),
        .snap_miss (snap_miss)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one edge and push its prediction.
    task automatic model(input logic rst, en, input logic [1:0] md,
                         input logic [3:0] qv, input logic r, ld, clr,
                         sreq, srdy);
        exp_t e;
        int nhi, nevt;
        bit w, os, us, ms;
        if (rst) begin
            m_hi = 0; m_evt = 0; m_ovf = 0; m_udf = 0; m_miss = 0;
            m_sv = 0; m_stot = 0; m_sevt = 0; m_total = 0;
        end else begin
            w = en && r && !ld;
            nhi = m_hi; os = 0; us = 0;
            if (ld) nhi = 0;
            else if (w && md == 2'd0) begin
                nhi = (m_hi + 1) % (HMAX + 1);
                os = (nhi == 0);
            end else if (w && (md == 2'd1 || md == 2'd2)) begin
                nhi = (m_hi + HMAX) % (HMAX + 1);
                us = (m_hi == 0);
            end
            nevt = clr ? 0 : m_evt;
            if (w && nevt < EMAX) nevt++;
            ms = m_sv && sreq;
            m_ovf  = (clr ? 0 : m_ovf) | os;
            m_udf  = (clr ? 0 : m_udf) | us;
            m_miss = (clr ? 0 : m_miss) | ms;
            m_total = nhi * 16 + qv;
            if (!m_sv && sreq) begin
                m_stot = m_total;
                m_sevt = nevt;
                m_sv = 1;
            end else if (m_sv && srdy) begin
                m_sv = 0;
            end
            m_hi = nhi;
            m_evt = nevt;
        end
        e.total = m_total[TOT_W-1:0];
        e.evt   = m_evt[EVT_W-1:0];
        e.ovf   = m_ovf[0];
        e.udf   = m_udf[0];
        e.sv    = m_sv[0];
        e.stot  = m_stot[TOT_W-1:0];
        e.sevt  = m_sevt[EVT_W-1:0];
        e.miss  = m_miss[0];
        sb.push_back(e);
    endtask

    task automatic step(input logic rst, en, input logic [1:0] md,
                        input logic [3:0] qv, input logic r, ld, clr,
                        sreq, srdy);
        exp_t e;
        reset = rst; enable = en; mode = md; Q = qv; rco = r;
        load = ld; clr_flags = clr; snap_req = sreq; snap_ready = srdy;
        model(rst, en, md, qv, r, ld, clr, sreq, srdy);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("total", total, e.total);
            check_eq("evt_cnt", evt_cnt, e.evt);
            check_eq("ovf", ovf, e.ovf);
            check_eq("udf", udf, e.udf);
            check_eq("snap_valid", snap_valid, e.sv);
            check_eq("snap_total", snap_total, e.stot);
            check_eq("snap_evt", snap_evt, e.sevt);
            check_eq("snap_miss", snap_miss, e.miss);
        end
    endtask

    task automatic run_up(input int n);
        for (int i = 0; i < n; i++) begin
            cq = (cq + 1) % 16;
            step(0, 1, 2'b00, cq[3:0], cq == 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1; enable = 0; mode = 0; Q = 0; rco = 0; load = 0;
        clr_flags = 0; snap_req = 0; snap_ready = 0;

        // reset with activity on the inputs
        step(1, 1, 2'b00, 4'h0, 1, 0, 0, 1, 0);
        step(1, 1, 2'b00, 4'h0, 1, 0, 0, 1, 0);
        step(0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        check_eq("rst_total", total, 0);
        check_eq("rst_valid", snap_valid, 0);
        check_eq("rst_evt", evt_cnt, 0);

        // up cascade
        cq = 0;
        step(0, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        run_up(47);
        check_eq("casc_2f", total, 8'h2F);
        run_up(1);
        check_eq("casc_30", total, 8'h30);
        check_eq("casc_evt", evt_cnt, 3);
        check_eq("casc_ovf", ovf, 0);

        // overflow
        run_up(192);
        check_eq("hi_f", total, 8'hF0);
        run_up(16);
        check_eq("ovf_total", total, 8'h00);
        check_eq("ovf_set", ovf, 1);
        run_up(32);
        check_eq("ovf_sticky", ovf, 1);
        step(0, 1, 2'b00, 4'h0, 0, 0, 1, 0, 0);
        check_eq("ovf_clr", ovf, 0);

        // underflow
        step(0, 1, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        step(0, 1, 2'b01, 4'hF, 1, 0, 0, 0, 0);
        check_eq("udf_total", total, 8'hFF);
        check_eq("udf_set", udf, 1);

        // load and gating
        step(0, 1, 2'b00, 4'h0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b00, 4'h0, 1, 0, 0, 0, 0);
        check_eq("hi5", total, 8'h50);
        step(0, 1, 2'b00, 4'h0, 1, 1, 0, 0, 0);
        check_eq("load_hi", total, 8'h00);
        check_eq("load_evt", evt_cnt, 5);
        step(0, 0, 2'b00, 4'h0, 1, 0, 0, 0, 0);
        check_eq("gate_hi", total, 8'h00);
        check_eq("gate_evt", evt_cnt, 5);

        // snapshot handshake
        step(0, 1, 2'b00, 4'h0, 1, 0, 0, 0, 0);
        step(0, 1, 2'b00, 4'h1, 0, 0, 0, 0, 0);
        step(0, 1, 2'b00, 4'h2, 0, 0, 0, 0, 0);
        step(0, 1, 2'b00, 4'h3, 0, 0, 0, 1, 0);
        check_eq("snap_cap", snap_total, 8'h13);
        check_eq("snap_v", snap_valid, 1);
        for (int i = 4; i < 9; i++) begin
            step(0, 1, 2'b00, 4'(i), 0, 0, 0, i == 6, 0);
            check_eq("snap_hold", snap_total, 8'h13);
        end
        check_eq("snap_miss", snap_miss, 1);
        step(0, 1, 2'b00, 4'h9, 0, 0, 0, 1, 1);
        check_eq("snap_rel", snap_valid, 0);
        check_eq("snap_keep", snap_total, 8'h13);
        step(0, 1, 2'b00, 4'hA, 0, 0, 0, 1, 0);
        check_eq("snap_new", snap_total, 8'h1A);
        step(0, 1, 2'b00, 4'hB, 0, 0, 1, 0, 1);
        check_eq("miss_clr", snap_miss, 0);

        // saturation and clear
        for (int i = 0; i < 300; i++) step(0, 1, 2'b11, 4'h0, 1, 0, 0, 0, 0);
        check_eq("evt_sat", evt_cnt, 255);
        step(0, 1, 2'b11, 4'h0, 1, 0, 1, 0, 0);
        check_eq("clr_wrap", evt_cnt, 1);
        step(0, 1, 2'b11, 4'h0, 0, 0, 1, 0, 0);
        check_eq("clr_only", evt_cnt, 0);

        // random traffic, including mid-handshake reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, 1'($urandom),
                 2'($urandom), 4'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
